mc_control: RTL and testbench
=============================

Name: mc_control

Overview:
- Multi-cycle MIPS control FSM. Drives the datapath muxes, register-file and memory strobes, and the 4-bit ALU opcode consumed by the team's ALU.
- Consumes the ALU `zero` flag for branch resolution and a memory-ready handshake for stalls.
- Sits between the instruction register and the datapath of the multi-cycle core.

Parameters:
- RST_STATE, 4'd0, state encoding loaded on reset (FETCH).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- opcode  in  6  IR[31:26]; valid from DECODE onward.
- funct  in  6  IR[5:0].
- zero  in  1  ALU zero flag (1 when alu_out==0).
- mem_ready  in  1  memory has completed the current read/write this cycle.
- alu_op  out  4  ADD 0010, SUB 0110, AND 0000, OR 0001, XOR 0111, NOR 1100.
- alu_src_a  out  1  0=PC, 1=reg A.
- alu_src_b  out  2  00=reg B, 01=const 4, 10=ext imm, 11=ext imm<<2.
- ext_zero  out  1  1=zero-extend imm (andi/ori/xori), 0=sign-extend.
- pc_source  out  2  00=ALU result, 01=ALUOut reg, 10=jump target.
- pc_en  out  1  PC load enable (unconditional or resolved branch).
- iord  out  1  memory address select: 0=PC, 1=ALUOut.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- ir_write  out  1  IR load.
- reg_dst  out  1  1=rd, 0=rt.
- mem_to_reg  out  1  1=MDR, 0=ALUOut.
- reg_write  out  1  register-file write.
- illegal_op  out  1  one-cycle pulse on an unsupported opcode/funct.
- state  out  4  current state, for debug.

Behaviour:
- Moore outputs decoded from the state register. Exceptions: `pc_en`, `ir_write` and `illegal_op` also depend on `zero`, `mem_ready` or the decode inputs, as stated below. Any output not listed for a state is 0.
- Reset: rst=1 at a rising edge loads FETCH, regardless of the current state (including mid-memory access).
  - While in FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=0010, pc_source=00. All other outputs 0.
- FETCH (0): requests memory. When mem_ready=1: ir_write=1, pc_en=1 (PC<=PC+4), next DECODE. Otherwise hold; ir_write=pc_en=0.
- DECODE (1): alu_src_a=0, alu_src_b=11, alu_op=0010 (branch target into ALUOut). Next state by opcode:
  - 000000 R → EXEC_R, only if funct is one of 100000–100111. Otherwise illegal.
  - 100011 lw, 101011 sw → MEM_ADDR.
  - 000100 beq, 000101 bne → BRANCH.
  - 001000 addi, 001001 addiu, 001100 andi, 001101 ori, 001110 xori → EXEC_I.
  - 000010 j → JUMP.
  - Anything else: illegal_op=1 this cycle, next FETCH.
- EXEC_R (2): alu_src_a=1, alu_src_b=00. alu_op from funct: add/addu 0010, sub/subu 0110, and 0000, or 0001, xor 0111, nor 1100. Next R_WB.
- R_WB (3): reg_dst=1, mem_to_reg=0, reg_write=1; next FETCH.
- MEM_ADDR (4): alu_src_a=1, alu_src_b=10, ext_zero=0, alu_op=0010. Next MEM_READ (lw) or MEM_WRITE (sw).
- MEM_READ (5): iord=1, mem_read=1. Hold until mem_ready, then MEM_WB.
- MEM_WB (6): reg_dst=0, mem_to_reg=1, reg_write=1; next FETCH.
- MEM_WRITE (7): iord=1, mem_write=1. Hold until mem_ready, then FETCH.
- EXEC_I (8): alu_src_a=1, alu_src_b=10. ext_zero=1 for andi/ori/xori. alu_op: addi/addiu 0010, andi 0000, ori 0001, xori 0111. Next I_WB.
- I_WB (9): reg_dst=0, mem_to_reg=0, reg_write=1; next FETCH.
- BRANCH (10): alu_src_a=1, alu_src_b=00, alu_op=0110, pc_source=01. pc_en=zero for beq, ~zero for bne. Next FETCH.
- JUMP (11): pc_source=10, pc_en=1; next FETCH.
- Unused encodings 12–15: all outputs 0, next FETCH.
- Latency in cycles (zero-wait memory):
  - R-type 4, I-arith 4, lw 5, sw 4, branch 3, j 3.
  - Each wait cycle in FETCH, MEM_READ or MEM_WRITE adds 1.
- mem_read and mem_write are never both 1. reg_write and mem_write are never both 1.

Test Plan:
- rst=1 for 2 cycles mid MEM_READ → state=0, mem_read=1, alu_op=0010, reg_write=0, pc_en=0 (mem_ready=0).
- opcode=000000 funct=100111 (nor), mem_ready=1 → states 0,1,2,3,0; alu_op=1100 in EXEC_R; reg_write=1, reg_dst=1 only in R_WB.
- lw with mem_ready low 3 cycles in MEM_READ → MEM_READ held 4 cycles, then MEM_WB with mem_to_reg=1, reg_write=1; total 8 cycles.
- beq with zero=1 → pc_en=1, pc_source=01 in BRANCH. beq zero=0 → pc_en=0. bne zero=0 → pc_en=1.
- ori → ext_zero=1, alu_op=0001, alu_src_b=10 in EXEC_I. addi → ext_zero=0, alu_op=0010.
- opcode=111111, then opcode=000000 funct=101010 → illegal_op pulses 1 cycle in DECODE each time; next state FETCH; no reg_write or mem_write.

Source files
------------

// File: rtl/mc_control.sv
// ============================================================================
// Module   : mc_control
// Purpose  : Multi-cycle MIPS control FSM driving datapath muxes, strobes and
//            the 4-bit ALU opcode.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mc_control #(
    parameter logic [3:0] RST_STATE = 4'd0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic [3:0] alu_op,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic       ext_zero,
    output logic [1:0] pc_source,
    output logic       pc_en,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       illegal_op,
    output logic [3:0] state
);

    localparam logic [3:0] S_FETCH     = 4'd0;
    localparam logic [3:0] S_DECODE    = 4'd1;
    localparam logic [3:0] S_EXEC_R    = 4'd2;
    localparam logic [3:0] S_R_WB      = 4'd3;
    localparam logic [3:0] S_MEM_ADDR  = 4'd4;
    localparam logic [3:0] S_MEM_READ  = 4'd5;
    localparam logic [3:0] S_MEM_WB    = 4'd6;
    localparam logic [3:0] S_MEM_WRITE = 4'd7;
    localparam logic [3:0] S_EXEC_I    = 4'd8;
    localparam logic [3:0] S_I_WB      = 4'd9;
    localparam logic [3:0] S_BRANCH    = 4'd10;
    localparam logic [3:0] S_JUMP      = 4'd11;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_XOR = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    logic [3:0] r_state;
    logic [3:0] w_next_state;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= RST_STATE;
        end else begin
            r_state <= w_next_state;
        end
    end

    assign state = r_state;

    always_comb begin
        w_next_state = S_FETCH;
        alu_op       = ALU_AND;
        alu_src_a    = 1'b0;
        alu_src_b    = 2'b00;
        ext_zero     = 1'b0;
        pc_source    = 2'b00;
        pc_en        = 1'b0;
        iord         = 1'b0;
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        ir_write     = 1'b0;
        reg_dst      = 1'b0;
        mem_to_reg   = 1'b0;
        reg_write    = 1'b0;
        illegal_op   = 1'b0;

        case (r_state)
            S_FETCH: begin
                mem_read     = 1'b1;
                alu_src_b    = 2'b01;
                alu_op       = ALU_ADD;
                ir_write     = mem_ready;
                pc_en        = mem_ready;
                w_next_state = mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                // Speculatively compute the branch target into ALUOut.
                alu_src_b = 2'b11;
                alu_op    = ALU_ADD;
                case (opcode)
                    OP_RTYPE: begin
                        if (funct[5:3] == 3'b100) begin
                            w_next_state = S_EXEC_R;
                        end else begin
                            illegal_op = 1'b1;
                        end
                    end
                    OP_LW, OP_SW:   w_next_state = S_MEM_ADDR;
                    OP_BEQ, OP_BNE: w_next_state = S_BRANCH;
                    OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI, OP_XORI:
                                    w_next_state = S_EXEC_I;
                    OP_J:           w_next_state = S_JUMP;
                    default:        illegal_op = 1'b1;
                endcase
            end
            S_EXEC_R: begin
                alu_src_a = 1'b1;
                case (funct[2:0])
                    3'b000, 3'b001: alu_op = ALU_ADD;
                    3'b010, 3'b011: alu_op = ALU_SUB;
                    3'b100:         alu_op = ALU_AND;
                    3'b101:         alu_op = ALU_OR;
                    3'b110:         alu_op = ALU_XOR;
                    default:        alu_op = ALU_NOR;
                endcase
                w_next_state = S_R_WB;
            end
            S_R_WB: begin
                reg_dst   = 1'b1;
                reg_write = 1'b1;
            end
            S_MEM_ADDR: begin
                alu_src_a    = 1'b1;
                alu_src_b    = 2'b10;
                alu_op       = ALU_ADD;
                w_next_state = (opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
            end
            S_MEM_READ: begin
                iord         = 1'b1;
                mem_read     = 1'b1;
                w_next_state = mem_ready ? S_MEM_WB : S_MEM_READ;
            end
            S_MEM_WB: begin
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
            end
            S_MEM_WRITE: begin
                iord         = 1'b1;
                mem_write    = 1'b1;
                w_next_state = mem_ready ? S_FETCH : S_MEM_WRITE;
            end
            S_EXEC_I: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                case (opcode)
                    OP_ANDI: begin alu_op = ALU_AND; ext_zero = 1'b1; end
                    OP_ORI:  begin alu_op = ALU_OR;  ext_zero = 1'b1; end
                    OP_XORI: begin alu_op = ALU_XOR; ext_zero = 1'b1; end
                    default: alu_op = ALU_ADD;
                endcase
                w_next_state = S_I_WB;
            end
            S_I_WB: begin
                reg_write = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_SUB;
                pc_source = 2'b01;
                pc_en     = (opcode == OP_BNE) ? ~zero : zero;
            end
            S_JUMP: begin
                pc_source = 2'b10;
                pc_en     = 1'b1;
            end
            default: begin
                w_next_state = S_FETCH;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_mc_control.sv
// ============================================================================
// Module   : tb_mc_control
// Purpose  : Self-checking bench for mc_control using an expected-output queue.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mc_control;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic [3:0] alu_op;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       ext_zero;
    logic [1:0] pc_source;
    logic       pc_en;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       illegal_op;
    logic [3:0] state;

    int n_checks = 0;
    int n_pass   = 0;

    logic [22:0] r_sb[$];
    logic [18:0] w_act;

    always #5 clk = ~clk;

    mc_control #(.RST_STATE(4'd0)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .opcode     (opcode),
        .funct      (funct),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .alu_op     (alu_op),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .ext_zero   (ext_zero),
        .pc_source  (pc_source),
        .pc_en      (pc_en),
        .iord       (iord),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .ir_write   (ir_write),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .reg_write  (reg_write),
        .illegal_op (illegal_op),
        .state      (state)
    );

    assign w_act = {alu_op, alu_src_a, alu_src_b, ext_zero, pc_source, pc_en, iord,
                    mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, illegal_op};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s @%0t: got %h expected %h", tag, $time, obs, exp);
        end
    endtask

    // Output table written straight from the state descriptions.
    function automatic logic [18:0] spec_outs(input logic [3:0] st, input logic [5:0] op,
                                              input logic [5:0] fn, input logic z,
                                              input logic rdy);
        logic [3:0] a_op;
        logic       sa, ez, pe, io, mr, mw, irw, rd, m2r, rw, ill;
        logic [1:0] sb, ps;
        logic       legal;
        {a_op, sa, sb, ez, ps, pe, io, mr, mw, irw, rd, m2r, rw, ill} = '0;
        case (st)
            4'd0: begin mr = 1; sb = 2'b01; a_op = 4'b0010; irw = rdy; pe = rdy; end
            4'd1: begin
                sb = 2'b11; a_op = 4'b0010;
                case (op)
                    6'b000000: legal = (fn >= 6'b100000) && (fn <= 6'b100111);
                    6'b100011, 6'b101011, 6'b000100, 6'b000101, 6'b001000,
                    6'b001001, 6'b001100, 6'b001101, 6'b001110, 6'b000010: legal = 1'b1;
                    default:   legal = 1'b0;
                endcase
                ill = ~legal;
            end
            4'd2: begin
                sa = 1;
                case (fn)
                    6'b100000, 6'b100001: a_op = 4'b0010;
                    6'b100010, 6'b100011: a_op = 4'b0110;
                    6'b100100: a_op = 4'b0000;
                    6'b100101: a_op = 4'b0001;
                    6'b100110: a_op = 4'b0111;
                    default:   a_op = 4'b1100;
                endcase
            end
            4'd3:  begin rd = 1; rw = 1; end
            4'd4:  begin sa = 1; sb = 2'b10; a_op = 4'b0010; end
            4'd5:  begin io = 1; mr = 1; end
            4'd6:  begin m2r = 1; rw = 1; end
            4'd7:  begin io = 1; mw = 1; end
            4'd8: begin
                sa = 1; sb = 2'b10;
                case (op)
                    6'b001100: begin a_op = 4'b0000; ez = 1; end
                    6'b001101: begin a_op = 4'b0001; ez = 1; end
                    6'b001110: begin a_op = 4'b0111; ez = 1; end
                    default:   a_op = 4'b0010;
                endcase
            end
            4'd9:  rw = 1;
            4'd10: begin sa = 1; a_op = 4'b0110; ps = 2'b01; pe = (op == 6'b000100) ? z : ~z; end
            4'd11: begin ps = 2'b10; pe = 1; end
            default: ;
        endcase
        return {a_op, sa, sb, ez, ps, pe, io, mr, mw, irw, rd, m2r, rw, ill};
    endfunction

    // Called just after a rising edge: drive this cycle's inputs and queue what
    // the DUT should show for the rest of the cycle.
    task automatic step(input logic [3:0] est, input logic rdy, input logic r);
        rst       = r;
        mem_ready = rdy;
        r_sb.push_back({est, spec_outs(est, opcode, funct, zero, rdy)});
        @(posedge clk);
        #1;
    endtask

    task automatic run(input logic [5:0] op, input logic [5:0] fn, input logic z,
                       input logic [31:0] path, input int len);
        opcode = op;
        funct  = fn;
        zero   = z;
        for (int i = 0; i < len; i++) begin
            step(path[4*(len-1-i) +: 4], 1'b1, 1'b0);
        end
    endtask

    always @(negedge clk) begin
        logic [22:0] e;
        if (r_sb.size() != 0) begin
            e = r_sb.pop_front();
            check("state", {28'd0, state}, {28'd0, e[22:19]});
            check("outputs", {13'd0, w_act}, {13'd0, e[18:0]});
        end
    end

    initial begin
        rst       = 1'b1;
        mem_ready = 1'b0;
        opcode    = 6'd0;
        funct     = 6'd0;
        zero      = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        step(4'd0, 1'b0, 1'b0);

        run(6'b000000, 6'b100111, 1'b0, 32'h0123, 4);
        for (int f = 0; f < 8; f++) begin
            run(6'b000000, 6'(32 + f), 1'b0, 32'h0123, 4);
        end

        opcode = 6'b100011;
        step(4'd0, 1'b1, 1'b0);
        step(4'd1, 1'b1, 1'b0);
        step(4'd4, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step(4'd5, 1'b0, 1'b0);
        step(4'd5, 1'b1, 1'b0);
        step(4'd6, 1'b1, 1'b0);

        run(6'b100011, 6'd0, 1'b0, 32'h01456, 5);
        run(6'b101011, 6'd0, 1'b0, 32'h0147, 4);

        opcode = 6'b101011;
        step(4'd0, 1'b0, 1'b0);
        step(4'd0, 1'b0, 1'b0);
        step(4'd0, 1'b1, 1'b0);
        step(4'd1, 1'b1, 1'b0);
        step(4'd4, 1'b1, 1'b0);
        step(4'd7, 1'b0, 1'b0);
        step(4'd7, 1'b1, 1'b0);

        run(6'b000100, 6'd0, 1'b1, 32'h01A, 3);
        run(6'b000100, 6'd0, 1'b0, 32'h01A, 3);
        run(6'b000101, 6'd0, 1'b0, 32'h01A, 3);
        run(6'b000101, 6'd0, 1'b1, 32'h01A, 3);

        run(6'b001101, 6'd0, 1'b0, 32'h0189, 4);
        run(6'b001000, 6'd0, 1'b0, 32'h0189, 4);
        run(6'b001001, 6'd0, 1'b0, 32'h0189, 4);
        run(6'b001100, 6'd0, 1'b0, 32'h0189, 4);
        run(6'b001110, 6'd0, 1'b0, 32'h0189, 4);
        run(6'b000010, 6'd0, 1'b0, 32'h01B, 3);

        run(6'b111111, 6'd0, 1'b0, 32'h01, 2);
        run(6'b000000, 6'b101010, 1'b0, 32'h01, 2);
        run(6'b000000, 6'b011000, 1'b0, 32'h01, 2);
        run(6'b000000, 6'b100101, 1'b0, 32'h0123, 4);

        // Reset asserted for two cycles while a load is waiting on memory.
        opcode = 6'b100011;
        step(4'd0, 1'b1, 1'b0);
        step(4'd1, 1'b1, 1'b0);
        step(4'd4, 1'b1, 1'b0);
        step(4'd5, 1'b0, 1'b0);
        step(4'd5, 1'b0, 1'b1);
        step(4'd0, 1'b0, 1'b1);
        step(4'd0, 1'b0, 1'b0);
        run(6'b100011, 6'd0, 1'b0, 32'h01456, 5);

        @(negedge clk);
        @(negedge clk);
        check("scoreboard_drain", r_sb.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
